iter_shift_unit: RTL
====================

Name: iter_shift_unit

Overview:
- Multi-cycle shift/rotate unit in the EX stage, alongside the ALU.
- Takes operand A and a shift amount, and iterates one bit position per cycle (four with the optional feature).
- Outputs a registered result for the GRF write-back mux.
- Uses a start/busy/done handshake so the controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width; must be 32 (shift amount is fixed at 5 bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  3  operation select: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal.
- A  input  32  operand to shift.
- B  input  32  shift amount source; only B[4:0] is used.
- busy  output  1  high while an operation is iterating.
- done  output  1  one-cycle pulse when result is valid.
- result  output  32  registered result; holds its value until the next completion.

Behaviour:
- Synchronous reset, active high: state=IDLE, busy=0, done=0, result=0, cnt=0, acc=0.
- Reset during RUN aborts the operation; no done pulse is produced.
- States are IDLE and RUN; a 5-bit cnt and a 32-bit acc are internal.
- IDLE, start=1 on edge k:
  - Latch op, acc<=A, cnt<=B[4:0].
  - If B[4:0]==0 or op is illegal: result<=A, done<=1 at edge k; stay IDLE; busy stays 0.
  - Otherwise: state<=RUN, busy<=1.
- RUN, on each edge:
  - acc<=step(acc), cnt<=cnt-1.
  - When cnt==1 before the edge: result<=step(acc), done<=1, busy<=0, state<=IDLE.
- Latency for n=B[4:0]>0: busy is high for exactly n cycles; done is high in the cycle after edge k+n.
- Step definitions (one bit per step):
  - SLL {acc[30:0],0}
  - SRL {0,acc[31:1]}
  - SRA {acc[31],acc[31:1]}
  - ROL {acc[30:0],acc[31]}
  - ROR {acc[0],acc[31:1]}
- done is high for exactly one cycle, then cleared on the next edge unless a new zero-latency completion occurs.
- start while busy=1 is ignored: no latch, no effect on the running op.
- start in the same cycle that done is high (state IDLE) is accepted normally.
- Inputs A, B and op may change freely after the start edge; they are not re-sampled.
- result changes only at a completion edge or at reset.
- Maximum shift is 31 (B[4:0]=31): 31 busy cycles. B[31:5] is ignored, so B=32 behaves as amount 0.

Optional Feature:
- Macro: ITER_SHIFT_STEP4_EN.
- Defined: in each RUN cycle, if cnt>=4 the unit applies four single-bit steps and sets cnt<=cnt-4; otherwise it applies one step and sets cnt<=cnt-1.
  - Completion is when cnt would reach 0.
  - Busy cycles = floor(n/4) + (n mod 4).
  - Example: n=31 -> 7+3 = 10 cycles.
- Not defined: one step per cycle, with latency exactly as in Behaviour.
- Results are identical in both builds; only timing differs.

Test Plan:
- Reset, then start op=3 (ROL), A=0x80000001, B=1 -> busy=1 for 1 cycle; done pulses the next cycle; result=0x00000003.
- op=2 (SRA), A=0x80000000, B=31 -> busy high 31 cycles (10 with ITER_SHIFT_STEP4_EN); result=0xFFFFFFFF; single done pulse.
- op=0 (SLL), A=0x12345678, B=0x20 (amount 0) -> busy never asserts; done is high the cycle after start; result=0x12345678. Repeat with op=6 -> same response.
- Start op=4 (ROR), A=0x0000000F, B=4; pulse start again with A=0xFFFFFFFF, B=1 two cycles later -> second start ignored; result=0xF0000000 after 4 busy cycles.
- Start op=1 (SRL), A=0xFFFFFFFF, B=10; assert reset for one edge at busy cycle 3 -> busy=0, done=0, result=0; no done pulse afterwards.
- Back-to-back: start accepted in the same cycle as done of the previous op (SLL A=1, B=2 -> 0x4; then ROL A=0x40000000, B=2 -> 0x00000001) -> two done pulses, correct results, no lost start.

Source files
------------

// File: rtl/iter_shift_unit.sv
// ----------------------------------------------------------------------------
// iter_shift_unit
//
// Multi-cycle shift/rotate unit for the EX stage. Operand A is shifted or
// rotated by B[4:0] positions, one bit position per RUN cycle (up to four
// per cycle when ITER_SHIFT_STEP4_EN is defined). The controller stalls the
// pipeline while busy is high; done pulses for one cycle when result is
// valid. result is registered and holds until the next completion.
//
// Build option:
//   ITER_SHIFT_STEP4_EN  - when defined, a RUN cycle with cnt>=4 applies four
//                          single-bit steps. Results are identical, only the
//                          number of busy cycles changes.
//
// Handshake: start is sampled only while busy=0 (state IDLE). A start taken
// on edge k with amount n>0 raises busy for the following cycles until the
// completion edge; done is high for the single cycle after that edge. A
// zero amount or an illegal op completes on edge k itself (busy stays 0).
// start while busy=1 is ignored. start in the same cycle as done is accepted.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   request pulse
//   op           in   0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
//   A            in   operand to shift
//   B            in   shift amount source, only B[4:0] used
//   busy         out  high while an operation is iterating
//   done         out  one-cycle completion pulse
//   result       out  registered result
//   dbg_state_o  out  current FSM state (0 IDLE, 1 RUN), debug only
// ----------------------------------------------------------------------------
module iter_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dbg_state_o
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    // One RUN cycle's worth of work, computed from the current acc/cnt.
    logic [WIDTH-1:0] acc_step;
    logic [4:0]       cnt_step;

    // Upper shift-amount bits are intentionally ignored.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:5];

    // Single-bit step for a legal op; illegal ops never reach RUN.
    function automatic logic [WIDTH-1:0] step1(input logic [2:0] o,
                                               input logic [WIDTH-1:0] v);
        case (o)
            OP_SLL:  step1 = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  step1 = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  step1 = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  step1 = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  step1 = {v[0], v[WIDTH-1:1]};
            default: step1 = v;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath: one step, or four when enabled and cnt allows.
    // ------------------------------------------------------------------
    always_comb begin
        acc_step = step1(op_q, acc_q);
        cnt_step = cnt_q - 5'd1;
`ifdef ITER_SHIFT_STEP4_EN
        if (cnt_q >= 5'd4) begin
            acc_step = step1(op_q, step1(op_q, step1(op_q, step1(op_q, acc_q))));
            cnt_step = cnt_q - 5'd4;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    acc_d = A;
                    cnt_d = B[4:0];
                    // Nothing to iterate: complete immediately with A.
                    if (B[4:0] == 5'd0 || op > OP_ROR) begin
                        result_d = A;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_step;
                // Completion is the cycle whose step brings cnt to zero.
                if (cnt_step == 5'd0) begin
                    result_d = acc_step;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q == S_RUN);
        done        = done_q;
        result      = result_q;
        dbg_state_o = state_q;
    end

endmodule
